// File: rtl/ctrl_pkg.sv
// Shared encodings for the 16-bit multi-cycle core control path.
// Imported by the controller, its decoder and the datapath.
package ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h5;
   localparam logic [3:0] OP_SW   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_BGT  = 4'h8;
   localparam logic [3:0] OP_JAL  = 4'h9;
   localparam logic [3:0] OP_JR   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hB;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam logic       A1_PC   = 1'b0;
   localparam logic       A1_A    = 1'b1;
   localparam logic [1:0] A2_B    = 2'd0;
   localparam logic [1:0] A2_TWO  = 2'd1;
   localparam logic [1:0] A2_IMM  = 2'd2;
   localparam logic [1:0] A2_ZERO = 2'd3;

   localparam logic [1:0] PC_ALU  = 2'd0;
   localparam logic [1:0] PC_TGT  = 2'd1;
   localparam logic [1:0] PC_A    = 2'd2;
   localparam logic       WB_ALU  = 1'b0;
   localparam logic       WB_MEM  = 1'b1;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_BGT,
      C_JAL, C_JR, C_HALT, C_ILL
   } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU op and
// branch/memory/store/illegal flags for the control FSM.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output iclass_t    iclass,
   output logic [2:0] aluop,
   output logic       is_branch,
   output logic       is_mem,
   output logic       is_store,
   output logic       illegal
);

   always_comb begin
      iclass    = C_ILL;
      aluop     = ALU_ADD;
      is_branch = 1'b0;
      is_mem    = 1'b0;
      is_store  = 1'b0;
      illegal   = 1'b0;
      unique case (1'b1)
         (opcode == OP_ADD): iclass = C_R;
         (opcode == OP_SUB): begin
            iclass = C_R;
            aluop  = ALU_SUB;
         end
         (opcode == OP_AND): begin
            iclass = C_R;
            aluop  = ALU_AND;
         end
         (opcode == OP_OR): begin
            iclass = C_R;
            aluop  = ALU_OR;
         end
         (opcode == OP_ADDI): iclass = C_ADDI;
         (opcode == OP_LW): begin
            iclass = C_LW;
            is_mem = 1'b1;
         end
         (opcode == OP_SW): begin
            iclass   = C_SW;
            is_mem   = 1'b1;
            is_store = 1'b1;
         end
         (opcode == OP_BEQ): begin
            iclass    = C_BEQ;
            aluop     = ALU_SUB;
            is_branch = 1'b1;
         end
         (opcode == OP_BGT): begin
            iclass    = C_BGT;
            aluop     = ALU_SUB;
            is_branch = 1'b1;
         end
         (opcode == OP_JAL):  iclass = C_JAL;
         (opcode == OP_JR):   iclass = C_JR;
         (opcode == OP_HALT): iclass = C_HALT;
         default:             illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Define CTRL_PERF_CNT_EN to add cycle_cnt/instr_cnt outputs.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        inst,
   input  logic               zero,
   input  logic               pos,
   input  logic               mem_ready,
   output logic [ALUOP_W-1:0] aluop,
   output logic               aluin1,
   output logic [1:0]         aluin2,
   output logic               mem_req,
   output logic               mem_we,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               tgt_write,
   output logic               reg_write,
   output logic               wb_src,
   output logic               halted,
   output logic               illegal
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0]        cycle_cnt,
   output logic [15:0]        instr_cnt
`endif
);

   state_t     state, state_n;
   iclass_t    iclass;
   logic [2:0] dec_aluop, op_sel;
   logic       is_branch, is_mem, is_store, dec_illegal;
   logic       pend, abort, take;
   logic       unused_inst;

   assign unused_inst = ^inst[11:0];

   ctrl_decode u_dec (
      .opcode    (inst[15:12]),
      .iclass    (iclass),
      .aluop     (dec_aluop),
      .is_branch (is_branch),
      .is_mem    (is_mem),
      .is_store  (is_store),
      .illegal   (dec_illegal)
   );

   assign take  = (iclass == C_BEQ && zero) || (iclass == C_BGT && pos);
   assign aluop = ALUOP_W'(op_sel);

   always_comb begin
      state_n   = state;
      op_sel    = ALU_ADD;
      aluin1    = A1_PC;
      aluin2    = A2_B;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_ALU;
      tgt_write = 1'b0;
      reg_write = 1'b0;
      wb_src    = WB_ALU;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            aluin2 = A2_TWO;
            // first cycle after an aborted request: swallow its late ready
            if (!abort) begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_n  = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            aluin2    = A2_IMM;
            tgt_write = 1'b1;
            if (iclass == C_HALT)  state_n = S_HALT;
            else if (dec_illegal)  state_n = S_TRAP;
            else                   state_n = S_EXEC;
         end
         S_EXEC: begin
            aluin1  = A1_A;
            state_n = S_FETCH;
            if (is_branch) begin
               op_sel   = dec_aluop;
               pc_write = take;
               pc_src   = take ? PC_TGT : PC_ALU;
            end else if (is_mem) begin
               aluin2  = A2_IMM;
               state_n = S_MEM;
            end else begin
               case (iclass)
                  C_R: begin
                     op_sel  = dec_aluop;
                     state_n = S_WB;
                  end
                  C_ADDI: begin
                     aluin2  = A2_IMM;
                     state_n = S_WB;
                  end
                  C_JAL: begin
                     aluin1    = A1_PC;
                     aluin2    = A2_ZERO;
                     reg_write = 1'b1;
                     pc_write  = 1'b1;
                     pc_src    = PC_TGT;
                  end
                  C_JR: begin
                     pc_write = 1'b1;
                     pc_src   = PC_A;
                  end
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (mem_ready) state_n = is_store ? S_FETCH : S_WB;
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_src    = (is_mem && !is_store) ? WB_MEM : WB_ALU;
            state_n   = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
      if (!rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         tgt_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
         abort   <= pend;
         pend    <= 1'b0;
      end else begin
         state <= state_n;
         abort <= 1'b0;
         pend  <= mem_req & ~mem_ready;
         if (state == S_DECODE && dec_illegal) illegal <= 1'b1;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt <= 16'd0;
         instr_cnt <= 16'd0;
      end else begin
         if (state != S_HALT && state != S_TRAP)
            cycle_cnt <= cycle_cnt + 16'd1;
         if (state_n == S_FETCH &&
             (state == S_EXEC || state == S_MEM || state == S_WB))
            instr_cnt <= instr_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: timeline reference model
// built from per-instruction phase rules, randomized streams.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] inst = 16'h0;
   logic        zero = 1'b0, pos = 1'b0, mem_ready = 1'b0;
   logic [2:0]  aluop;
   logic        aluin1;
   logic [1:0]  aluin2, pc_src;
   logic        mem_req, mem_we, ir_write, pc_write;
   logic        tgt_write, reg_write, wb_src, halted, illegal;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0] cycle_cnt, instr_cnt;
`endif

   multicycle_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .inst      (inst),
      .zero      (zero),
      .pos       (pos),
      .mem_ready (mem_ready),
      .aluop     (aluop),
      .aluin1    (aluin1),
      .aluin2    (aluin2),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .tgt_write (tgt_write),
      .reg_write (reg_write),
      .wb_src    (wb_src),
      .halted    (halted),
      .illegal   (illegal)
`ifdef CTRL_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit req_open = 1'b0;

   typedef struct {
      int          op;
      logic [15:0] word;
      int          f;
      int          m;
      bit          z;
      bit          p;
   } ins_t;

   ins_t prog[$];

   localparam int MAXC = 1024;
   // {halted, illegal, mem_req, mem_we, ir_write, pc_write, tgt_write, reg_write}
   bit [7:0]    e_vec[MAXC];
   bit          e_sel[MAXC];
   bit          e_a1[MAXC];
   bit [1:0]    e_a2[MAXC];
   bit [2:0]    e_aop[MAXC];
   bit [1:0]    e_pcs[MAXC];
   bit          e_wbs[MAXC];
   bit          d_rdy[MAXC];
   logic [15:0] d_inst[MAXC];
   bit          d_z[MAXC];
   bit          d_p[MAXC];

   function automatic bit [7:0] obs();
      return {halted, illegal, mem_req, mem_we,
              ir_write, pc_write, tgt_write, reg_write};
   endfunction

   function automatic int lat(input int op, input int f, input int m);
      case (op)
         0, 1, 2, 3, 4: return f + 4;
         5:             return f + 5 + m;
         6:             return f + 4 + m;
         default:       return f + 3;
      endcase
   endfunction

   task automatic step(input bit r, input bit rdy, input logic [15:0] w,
                       input bit z, input bit p);
      @(negedge clk);
      rst = r;
      mem_ready = rdy;
      inst = w;
      zero = z;
      pos = p;
      #1;
   endtask

   task automatic set_sel(input int c, input bit a1, input bit [1:0] a2,
                          input bit [2:0] aop);
      e_sel[c] = 1'b1;
      e_a1[c]  = a1;
      e_a2[c]  = a2;
      e_aop[c] = aop;
   endtask

   task automatic set_wb(input int c, input bit src);
      e_vec[c][0] = 1'b1;
      e_wbs[c]    = src;
   endtask

   task automatic build(output int total);
      int t, f, m, x, op, len;
      for (int c = 0; c < MAXC; c++) begin
         e_vec[c] = '0; e_sel[c] = 0; e_a1[c] = 0; e_a2[c] = 0;
         e_aop[c] = 0; e_pcs[c] = 0; e_wbs[c] = 0;
         d_rdy[c] = 1'($urandom_range(0, 1));
         d_inst[c] = 16'h0; d_z[c] = 0; d_p[c] = 0;
      end
      t = 0;
      foreach (prog[i]) begin
         op = prog[i].op; f = prog[i].f; m = prog[i].m;
         len = lat(op, f, m);
         for (int c = t; c < t + len; c++) begin
            d_inst[c] = prog[i].word;
            d_z[c] = prog[i].z;
            d_p[c] = prog[i].p;
         end
         for (int r = 0; r <= f; r++) begin
            e_vec[t+r][5] = 1'b1;
            set_sel(t + r, 1'b0, 2'd1, 3'd0);
            d_rdy[t+r] = (r == f);
         end
         e_vec[t+f][3] = 1'b1;
         e_vec[t+f][2] = 1'b1;
         e_pcs[t+f] = 2'd0;
         e_vec[t+f+1][1] = 1'b1;
         set_sel(t + f + 1, 1'b0, 2'd2, 3'd0);
         x = t + f + 2;
         case (op)
            0, 1, 2, 3: begin
               set_sel(x, 1'b1, 2'd0, 3'(op));
               set_wb(x + 1, 1'b0);
            end
            4: begin
               set_sel(x, 1'b1, 2'd2, 3'd0);
               set_wb(x + 1, 1'b0);
            end
            5, 6: begin
               set_sel(x, 1'b1, 2'd2, 3'd0);
               for (int r = 0; r <= m; r++) begin
                  e_vec[x+1+r][5] = 1'b1;
                  e_vec[x+1+r][4] = (op == 6);
                  d_rdy[x+1+r] = (r == m);
               end
               if (op == 5) set_wb(x + 2 + m, 1'b1);
            end
            7, 8: begin
               set_sel(x, 1'b1, 2'd0, 3'd1);
               if ((op == 7) ? prog[i].z : prog[i].p) begin
                  e_vec[x][2] = 1'b1;
                  e_pcs[x] = 2'd1;
               end
            end
            9: begin
               set_sel(x, 1'b0, 2'd3, 3'd0);
               set_wb(x, 1'b0);
               e_vec[x][2] = 1'b1;
               e_pcs[x] = 2'd1;
            end
            default: begin
               e_vec[x][2] = 1'b1;
               e_pcs[x] = 2'd2;
            end
         endcase
         t += len;
      end
      e_vec[t][5] = 1'b1;
      set_sel(t, 1'b0, 2'd1, 3'd0);
      d_rdy[t] = 1'b0;
      total = t + 1;
   endtask

   task automatic run_stream(input string name);
      int total;
      bit [7:0] v;
      build(total);
      for (int c = 0; c < total; c++) begin
         step(1'b1, d_rdy[c], d_inst[c], d_z[c], d_p[c]);
         v = obs();
         n_tests++;
         if (v !== e_vec[c]) begin
            n_fail++;
            $display("FAIL %s cyc %0d strobes got %b exp %b",
                     name, c, v, e_vec[c]);
         end
         if (e_sel[c]) begin
            n_tests++;
            if ({aluin1, aluin2, aluop} !== {e_a1[c], e_a2[c], e_aop[c]}) begin
               n_fail++;
               $display("FAIL %s cyc %0d a1/a2/op got %b/%0d/%0d exp %b/%0d/%0d",
                        name, c, aluin1, aluin2, aluop,
                        e_a1[c], e_a2[c], e_aop[c]);
            end
         end
         if (e_vec[c][2]) begin
            n_tests++;
            if (pc_src !== e_pcs[c]) begin
               n_fail++;
               $display("FAIL %s cyc %0d pc_src got %0d exp %0d",
                        name, c, pc_src, e_pcs[c]);
            end
         end
         if (e_vec[c][0]) begin
            n_tests++;
            if (wb_src !== e_wbs[c]) begin
               n_fail++;
               $display("FAIL %s cyc %0d wb_src got %0d exp %0d",
                        name, c, wb_src, e_wbs[c]);
            end
         end
      end
      req_open = 1'b1;
   endtask

   task automatic expect_vec(input string name, input bit [7:0] exp);
      bit [7:0] v;
      v = obs();
      n_tests++;
      if (v !== exp) begin
         n_fail++;
         $display("FAIL %s got %b exp %b", name, v, exp);
      end
   endtask

   task automatic do_reset(input int n);
      bit [7:0] v;
      for (int k = 0; k < n; k++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 16'h0, 1'b0, 1'b0);
         v = obs();
         n_tests++;
         if (v[5:0] !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got %b exp 000000", v[5:0]);
         end
         if (k > 0) expect_vec("reset_state", 8'b0);
      end
      if (n == 1 && req_open) begin
         step(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0);
         expect_vec("stale_ready_ignored", 8'b0);
      end
      req_open = 1'b0;
   endtask

   function automatic ins_t mk(input int op, input int f, input int m,
                               input bit z, input bit p);
      ins_t r;
      r.op = op;
      r.word = {4'(op), 12'($urandom)};
      r.f = f;
      r.m = m;
      r.z = z;
      r.p = p;
      return r;
   endfunction

   task automatic test_reset();
      do_reset(3);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      expect_vec("first_fetch", 8'b0010_0000);
      n_tests++;
      if ({aluin1, aluin2, aluop} !== {1'b0, 2'd1, 3'd0}) begin
         n_fail++;
         $display("FAIL fetch_sel got %b/%0d/%0d exp 0/1/0",
                  aluin1, aluin2, aluop);
      end
      req_open = 1'b1;
   endtask

   task automatic test_add();
      ins_t r;
      r = mk(0, 0, 0, 0, 0);
      r.word = 16'h0123;
      prog = {r};
      run_stream("add");
   endtask

   task automatic test_lw_wait();
      ins_t r;
      r = mk(5, 0, 3, 0, 0);
      r.word = 16'h5abc;
      prog = {r};
      run_stream("lw_wait");
   endtask

   task automatic test_branches();
      prog = {mk(7, 0, 0, 1, 0), mk(7, 1, 0, 0, 1), mk(8, 0, 0, 0, 1),
              mk(8, 0, 0, 1, 0), mk(9, 2, 0, 0, 0), mk(10, 0, 0, 0, 0),
              mk(6, 0, 2, 0, 0), mk(4, 2, 0, 0, 0), mk(3, 1, 0, 0, 0)};
      run_stream("branch_jump");
   endtask

   task automatic test_random_stream();
      prog.delete();
      for (int i = 0; i < 40; i++)
         prog.push_back(mk($urandom_range(0, 10), $urandom_range(0, 3),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1))));
      run_stream("random");
   endtask

   task automatic test_halt();
      do_reset(2);
      step(1'b1, 1'b1, 16'hB000, 1'b0, 1'b0);
      expect_vec("halt_fetch", 8'b0010_1100);
      step(1'b1, 1'($urandom_range(0, 1)), 16'hB000, 1'b0, 1'b0);
      expect_vec("halt_decode", 8'b0000_0010);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 16'h0123, 1'b1, 1'b1);
         expect_vec("halt_hold", 8'b1000_0000);
      end
      do_reset(2);
   endtask

   task automatic test_trap();
      step(1'b1, 1'b1, 16'hC000, 1'b0, 1'b0);
      expect_vec("trap_fetch", 8'b0010_1100);
      step(1'b1, 1'($urandom_range(0, 1)), 16'hC000, 1'b0, 1'b0);
      expect_vec("trap_decode", 8'b0000_0010);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 16'h0123, 1'b0, 1'b0);
         expect_vec("trap_hold", 8'b0100_0000);
      end
      do_reset(2);
   endtask

   task automatic test_reset_abort();
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      expect_vec("abort_wait1", 8'b0010_0000);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      expect_vec("abort_wait2", 8'b0010_0000);
      req_open = 1'b1;
      do_reset(1);
      step(1'b1, 1'b0, 16'h0123, 1'b0, 1'b0);
      expect_vec("fresh_request", 8'b0010_0000);
      step(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0);
      expect_vec("fresh_fetch_done", 8'b0010_1100);
      do_reset(2);
   endtask

`ifdef CTRL_PERF_CNT_EN
   task automatic test_perf();
      do_reset(2);
      prog.delete();
      for (int i = 0; i < 10; i++) prog.push_back(mk(0, 0, 0, 0, 0));
      run_stream("perf_adds");
      n_tests++;
      if (instr_cnt !== 16'd10 || cycle_cnt !== 16'd40) begin
         n_fail++;
         $display("FAIL perf_cnt got instr=%0d cycle=%0d exp instr=10 cycle=40",
                  instr_cnt, cycle_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branches();
      test_random_stream();
      test_halt();
      test_trap();
      test_reset_abort();
`ifdef CTRL_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
